// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage between the PC register and decode. Issues one
//   request/grant/response transaction per instruction to instruction
//   memory, holds the returned word for decode behind a valid/ready
//   handshake, and pulses pc_en once per delivered instruction.
//   Misaligned PCs, bus errors and response timeouts deliver NOP_INSTR
//   with fault/fault_cause set. A flush abandons any fetch in progress;
//   if a response is still owed by memory, it is swallowed later (stale).
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   pc_in, fetch_en     PC to fetch and permission to start a fetch
//   flush               abandon in-flight fetch or held instruction
//   imem_req/addr/gnt   request channel to instruction memory
//   imem_rvalid/rdata/err  response channel (err qualified by rvalid)
//   instr_valid/ready   handshake to decode
//   instr_out, instr_pc instruction word and its PC
//   fault, fault_cause  fault flag and cause (0 none,1 misaligned,2 timeout,3 bus error)
//   pc_en               PC register may advance this edge (combinational)
//   busy                fetch in progress or stale response outstanding
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        fetch_en,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        pc_en,
    output logic        busy
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned    CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_TIMEOUT  = 2'd2,
        CAUSE_BUSERR   = 2'd3
    } cause_t;

    state_t        state, state_d;
    logic          stale, stale_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [31:0]   pc_q;
    logic [31:0]   instr_q;
    logic [31:0]   instr_pc_q;
    logic          fault_q;
    cause_t        cause_q;

    logic          capture;
    logic          load;
    logic [31:0]   load_instr;
    logic          load_fault;
    cause_t        load_cause;

    always_comb begin
        state_d    = state;
        stale_d    = stale;
        cnt_d      = cnt;
        capture    = 1'b0;
        load       = 1'b0;
        load_instr = NOP_INSTR;
        load_fault = 1'b0;
        load_cause = CAUSE_NONE;

        // A stale response can only arrive while idle: requests are
        // blocked until it has been consumed.
        if (stale && imem_rvalid) begin
            stale_d = 1'b0;
        end

        unique case (state)
            S_IDLE: begin
                if (fetch_en && !flush && !stale) begin
                    capture = 1'b1;
                    if (pc_in[1:0] != 2'b00) begin
                        load       = 1'b1;
                        load_fault = 1'b1;
                        load_cause = CAUSE_MISALIGN;
                        state_d    = S_HOLD;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (flush) begin
                    state_d = S_IDLE;
                    // Granted request still owes a response.
                    if (imem_gnt) begin
                        stale_d = 1'b1;
                    end
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt + 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                    // Response arriving with the flush is simply dropped.
                    stale_d = !imem_rvalid;
                end else if (imem_rvalid) begin
                    load  = 1'b1;
                    state_d = S_HOLD;
                    if (imem_err) begin
                        load_fault = 1'b1;
                        load_cause = CAUSE_BUSERR;
                    end else begin
                        load_instr = imem_rdata;
                    end
                end else if (cnt == CNT_LAST) begin
                    load       = 1'b1;
                    load_fault = 1'b1;
                    load_cause = CAUSE_TIMEOUT;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush || instr_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            stale      <= 1'b0;
            cnt        <= '0;
            pc_q       <= '0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= '0;
            fault_q    <= 1'b0;
            cause_q    <= CAUSE_NONE;
        end else begin
            state <= state_d;
            stale <= stale_d;
            cnt   <= cnt_d;
            if (capture) begin
                pc_q       <= pc_in;
                instr_pc_q <= pc_in;
            end
            if (load) begin
                instr_q <= load_instr;
                fault_q <= load_fault;
                cause_q <= load_cause;
            end
        end
    end

    assign imem_req    = (state == S_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state == S_HOLD);
    assign instr_out   = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign pc_en       = (state == S_HOLD) && instr_ready && !flush;
    assign busy        = (state != S_IDLE) || stale;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int unsigned TIMEOUT = 16;
    localparam logic [31:0] NOP     = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        fetch_en;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        pc_en;
    logic        busy;

    instr_fetch_unit #(
        .TIMEOUT   (TIMEOUT),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .fault       (fault),
        .fault_cause (fault_cause),
        .pc_en       (pc_en),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
        logic [1:0]  cause;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_addr_q[$];
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    logic        req_forbidden = 1'b0;

    logic [31:0] hold_out, hold_pc;
    logic        hold_fault;
    logic [1:0]  hold_cause;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // What decode must see for a fetch, from the architectural rules only.
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] data,
                                   input logic err, input logic timed_out);
        exp_t e;
        e.pc = pc;
        if (pc[1:0] != 2'b00)  begin e.instr = NOP;  e.fault = 1'b1; e.cause = 2'd1; end
        else if (timed_out)    begin e.instr = NOP;  e.fault = 1'b1; e.cause = 2'd2; end
        else if (err)          begin e.instr = NOP;  e.fault = 1'b1; e.cause = 2'd3; end
        else                   begin e.instr = data; e.fault = 1'b0; e.cause = 2'd0; end
        return e;
    endfunction

    // Compare process: every non-reset cycle, against the scoreboards.
    always @(negedge clk) begin
        if (!reset) begin
            chk("pc_en_rule", pc_en, instr_valid && instr_ready && !flush);
            if (pc_en) pulses++;
            if (req_forbidden) chk("no_req_allowed", imem_req, 1'b0);
            if (instr_valid && exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_hold actual=valid required=idle");
            end
            if (imem_req && imem_gnt) begin
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_grant addr=%h", imem_addr);
                end else begin
                    chk("req_addr", imem_addr, exp_addr_q.pop_front());
                end
            end
            if (instr_valid && instr_ready && !flush && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("deliver_instr", instr_out, e.instr);
                chk("deliver_pc", instr_pc, e.pc);
                chk("deliver_fault", fault, e.fault);
                chk("deliver_cause", fault_cause, e.cause);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // rsp_dly: WAIT cycle (1-based) carrying rvalid; 0 means never (timeout).
    // ending: 0 accept with ready, 1 flush together with ready, 2 leave in HOLD.
    task automatic fetch(input logic [31:0] pc, input int gnt_dly, input int rsp_dly,
                         input logic [31:0] data, input logic err,
                         input int ready_dly, input int ending);
        exp_q.push_back(model(pc, data, err, rsp_dly == 0));
        pc_in    = pc;
        fetch_en = 1'b1;
        if (pc[1:0] != 2'b00) req_forbidden = 1'b1;
        step();
        fetch_en = 1'b0;
        if (pc[1:0] == 2'b00) begin
            for (int i = 0; i < gnt_dly; i++) begin
                chk("req_wait_addr", imem_addr, pc);
                chk("req_wait_req", imem_req, 1'b1);
                step();
            end
            chk("req_before_gnt", imem_req, 1'b1);
            imem_gnt = 1'b1;
            exp_addr_q.push_back(pc);
            step();
            imem_gnt = 1'b0;
            if (rsp_dly == 0) begin
                repeat (TIMEOUT - 1) step();
                chk("timeout_not_early", instr_valid, 1'b0);
                step();
            end else begin
                repeat (rsp_dly - 1) step();
                imem_rvalid = 1'b1;
                imem_rdata  = data;
                imem_err    = err;
                step();
                imem_rvalid = 1'b0;
                imem_err    = 1'b0;
                imem_rdata  = '0;
            end
        end
        req_forbidden = 1'b0;
        chk("hold_reached", instr_valid, 1'b1);
        hold_out   = instr_out;
        hold_pc    = instr_pc;
        hold_fault = fault;
        hold_cause = fault_cause;
        for (int i = 0; i < ready_dly; i++) begin
            chk("bp_valid", instr_valid, 1'b1);
            chk("bp_instr", instr_out, hold_out);
            chk("bp_pc", instr_pc, hold_pc);
            chk("bp_pc_en", pc_en, 1'b0);
            step();
        end
        if (ending == 0) begin
            instr_ready = 1'b1;
            #1;
            chk("pc_en_on_ready", pc_en, 1'b1);
            step();
            instr_ready = 1'b0;
            chk("idle_after_ready", instr_valid, 1'b0);
        end else if (ending == 1) begin
            instr_ready = 1'b1;
            flush       = 1'b1;
            #1;
            chk("flush_ready_pc_en", pc_en, 1'b0);
            step();
            flush       = 1'b0;
            instr_ready = 1'b0;
            chk("idle_after_flush", instr_valid, 1'b0);
            exp_q.delete();
        end
    endtask

    task automatic check_reset_values();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr_out, 32'h00000013);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_cause", fault_cause, 2'd0);
        chk("rst_pc_en", pc_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        reset = 1'b1; pc_in = '0; fetch_en = 1'b0; flush = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; imem_err = 1'b0;
        instr_ready = 1'b0;
        repeat (3) step();
        flush = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_values();

        // Normal fetch
        p0 = pulses;
        fetch(32'h100, 0, 2, 32'h00500093, 1'b0, 0, 0);
        chk("norm_instr", hold_out, 32'h00500093);
        chk("norm_pc", hold_pc, 32'h100);
        chk("norm_fault", hold_fault, 1'b0);
        chk("norm_addr", imem_addr, 32'h100);
        chk("norm_one_pulse", pulses - p0, 1);

        // Backpressure for 5 cycles
        p0 = pulses;
        fetch(32'h180, 1, 3, 32'h00C00193, 1'b0, 5, 0);
        chk("bp_data", hold_out, 32'h00C00193);
        chk("bp_one_pulse", pulses - p0, 1);

        // Misaligned
        fetch(32'h102, 0, 1, 32'h0, 1'b0, 1, 0);
        chk("mis_instr", hold_out, 32'h00000013);
        chk("mis_fault", hold_fault, 1'b1);
        chk("mis_cause", hold_cause, 2'd1);
        chk("mis_pc", hold_pc, 32'h102);

        // Bus error; fault registers persist into IDLE
        fetch(32'h300, 2, 1, 32'h12345678, 1'b1, 0, 0);
        chk("err_instr", hold_out, 32'h00000013);
        chk("err_cause", hold_cause, 2'd3);
        chk("err_fault_held", fault, 1'b1);
        chk("err_cause_held", fault_cause, 2'd3);

        // Timeout
        fetch(32'h400, 0, 0, 32'h0, 1'b0, 0, 0);
        chk("to_instr", hold_out, 32'h00000013);
        chk("to_cause", hold_cause, 2'd2);
        chk("to_pc", hold_pc, 32'h400);

        // Flush in WAIT, late response must be swallowed
        pc_in = 32'h200; fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        imem_gnt = 1'b1;
        exp_addr_q.push_back(32'h200);
        step();
        imem_gnt = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        fetch_en = 1'b1;
        pc_in = 32'h104;
        req_forbidden = 1'b1;
        chk("stale_busy", busy, 1'b1);
        chk("stale_no_valid", instr_valid, 1'b0);
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEADBEEF;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        req_forbidden = 1'b0;
        chk("stale_cleared", busy, 1'b0);
        chk("stale_dropped", instr_valid, 1'b0);
        fetch(32'h104, 0, 2, 32'h00A00113, 1'b0, 0, 0);
        chk("after_stale_instr", hold_out, 32'h00A00113);
        chk("after_stale_pc", hold_pc, 32'h104);

        // Flush in REQ without grant: no stale
        pc_in = 32'h500; fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        chk("reqflush_req", imem_req, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("reqflush_busy", busy, 1'b0);
        chk("reqflush_req_off", imem_req, 1'b0);

        // Flush together with ready in HOLD
        p0 = pulses;
        fetch(32'h600, 0, 1, 32'h00100073, 1'b0, 2, 1);
        chk("flush_hold_no_pulse", pulses - p0, 0);

        // Reset while holding
        fetch(32'h700, 0, 1, 32'h00200093, 1'b0, 1, 2);
        reset = 1'b1;
        step();
        exp_q.delete();
        reset = 1'b0;
        #1;
        check_reset_values();

        // Recovery after reset
        fetch(32'h800, 0, 1, 32'h00300113, 1'b0, 0, 0);
        chk("recover_instr", hold_out, 32'h00300113);

        step();
        chk("exp_drained", exp_q.size(), 0);
        chk("addr_drained", exp_addr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
